// File: rtl/riscv_muldiv_issue.sv
// Single-entry issue stage for the mul/div unit: RAW/WAW scoreboard, zero-bubble writeback forwarding.
// Issue is combinational from the issue register; stall_i or a hazard holds it and drops fetch_accept_o.
module riscv_muldiv_issue (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        fetch_valid_i,
  input  logic [55:0] fetch_instr_i,
  input  logic [31:0] fetch_opcode_i,
  input  logic [31:0] fetch_pc_i,
  input  logic [4:0]  fetch_rd_idx_i,
  input  logic [4:0]  fetch_ra_idx_i,
  input  logic [4:0]  fetch_rb_idx_i,
  output logic        fetch_accept_o,

  output logic [4:0]  rf_ra_idx_o,
  output logic [4:0]  rf_rb_idx_o,
  input  logic [31:0] rf_ra_value_i,
  input  logic [31:0] rf_rb_value_i,

  output logic        opcode_valid_o,
  output logic [55:0] opcode_instr_o,
  output logic [31:0] opcode_opcode_o,
  output logic [31:0] opcode_pc_o,
  output logic [4:0]  opcode_rd_idx_o,
  output logic [4:0]  opcode_ra_idx_o,
  output logic [4:0]  opcode_rb_idx_o,
  output logic [31:0] opcode_ra_operand_o,
  output logic [31:0] opcode_rb_operand_o,
  input  logic        stall_i,

  input  logic [4:0]  writeback_idx_i,
  input  logic [31:0] writeback_value_i,
  input  logic        writeback_squash_i,

  output logic [4:0]  rf_wr_idx_o,
  output logic [31:0] rf_wr_value_o,
  input  logic        flush_i,
  output logic        busy_o
);

  typedef struct packed {
    logic [55:0] instr;
    logic [31:0] opcode;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  ra;
    logic [4:0]  rb;
  } issue_t;

  logic        issue_valid_q;
  issue_t      issue_q;
  issue_t      fetch_w;
  logic [31:0] pending_q;

  logic        wb_fwd_w;
  logic [31:0] wb_fwd_mask_w;
  logic [31:0] pending_eff_w;
  logic [31:0] pending_set_w;
  logic [31:0] pending_clr_w;
  logic [31:0] pending_nxt_w;
  logic        hazard_w;
  logic        issue_fire_w;
  logic        fetch_take_w;

  // A non-squashed writeback both forwards its value and releases its scoreboard bit this cycle.
  assign wb_fwd_w      = !writeback_squash_i && (writeback_idx_i != 5'd0);
  assign wb_fwd_mask_w = wb_fwd_w ? (32'd1 << writeback_idx_i) : 32'd0;
  assign pending_eff_w = pending_q & ~wb_fwd_mask_w;

  assign hazard_w       = pending_eff_w[issue_q.ra] | pending_eff_w[issue_q.rb] |
                          pending_eff_w[issue_q.rd];
  assign opcode_valid_o = issue_valid_q && !hazard_w;
  assign issue_fire_w   = opcode_valid_o && !stall_i;
  assign fetch_accept_o = !flush_i && (!issue_valid_q || issue_fire_w);
  assign fetch_take_w   = fetch_valid_i && fetch_accept_o;

  assign fetch_w.instr  = fetch_instr_i;
  assign fetch_w.opcode = fetch_opcode_i;
  assign fetch_w.pc     = fetch_pc_i;
  assign fetch_w.rd     = fetch_rd_idx_i;
  assign fetch_w.ra     = fetch_ra_idx_i;
  assign fetch_w.rb     = fetch_rb_idx_i;

  // Squashed writebacks still clear the bit; a same-cycle set of that index wins.
  assign pending_set_w = (issue_fire_w && (issue_q.rd != 5'd0)) ? (32'd1 << issue_q.rd) : 32'd0;
  assign pending_clr_w = (writeback_idx_i != 5'd0) ? (32'd1 << writeback_idx_i) : 32'd0;
  assign pending_nxt_w = ((pending_q & ~pending_clr_w) | pending_set_w) & 32'hFFFF_FFFE;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issue_valid_q <= 1'b0;
      issue_q       <= '0;
      pending_q     <= '0;
    end else begin
      if (fetch_take_w) begin
        issue_valid_q <= 1'b1;
        issue_q       <= fetch_w;
      end else if (issue_fire_w || flush_i) begin
        issue_valid_q <= 1'b0;
      end
      pending_q <= pending_nxt_w;
    end
  end

  function automatic logic [31:0] operand(input logic [4:0]  idx,
                                          input logic [31:0] rf_val,
                                          input logic [4:0]  wb_idx,
                                          input logic        wb_ok,
                                          input logic [31:0] wb_val);
    if (idx == 5'd0)
      return 32'd0;
    else if (wb_ok && (idx == wb_idx))
      return wb_val;
    else
      return rf_val;
  endfunction

  assign rf_ra_idx_o = issue_q.ra;
  assign rf_rb_idx_o = issue_q.rb;

  assign opcode_instr_o      = issue_q.instr;
  assign opcode_opcode_o     = issue_q.opcode;
  assign opcode_pc_o         = issue_q.pc;
  assign opcode_rd_idx_o     = issue_q.rd;
  assign opcode_ra_idx_o     = issue_q.ra;
  assign opcode_rb_idx_o     = issue_q.rb;
  assign opcode_ra_operand_o = operand(issue_q.ra, rf_ra_value_i, writeback_idx_i, wb_fwd_w,
                                       writeback_value_i);
  assign opcode_rb_operand_o = operand(issue_q.rb, rf_rb_value_i, writeback_idx_i, wb_fwd_w,
                                       writeback_value_i);

  assign rf_wr_idx_o   = writeback_squash_i ? 5'd0 : writeback_idx_i;
  assign rf_wr_value_o = writeback_value_i;
  assign busy_o        = issue_valid_q || (|pending_q);

endmodule

// File: tb/tb_riscv_muldiv_issue.sv
// Bench for riscv_muldiv_issue: directed scenarios plus random traffic, all checked against a reference model.
module tb_riscv_muldiv_issue;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fetch_valid_i;
  logic [55:0] fetch_instr_i;
  logic [31:0] fetch_opcode_i, fetch_pc_i;
  logic [4:0]  fetch_rd_idx_i, fetch_ra_idx_i, fetch_rb_idx_i;
  logic        fetch_accept_o;
  logic [4:0]  rf_ra_idx_o, rf_rb_idx_o;
  logic [31:0] rf_ra_value_i, rf_rb_value_i;
  logic        opcode_valid_o;
  logic [55:0] opcode_instr_o;
  logic [31:0] opcode_opcode_o, opcode_pc_o;
  logic [4:0]  opcode_rd_idx_o, opcode_ra_idx_o, opcode_rb_idx_o;
  logic [31:0] opcode_ra_operand_o, opcode_rb_operand_o;
  logic        stall_i;
  logic [4:0]  writeback_idx_i;
  logic [31:0] writeback_value_i;
  logic        writeback_squash_i;
  logic [4:0]  rf_wr_idx_o;
  logic [31:0] rf_wr_value_o;
  logic        flush_i;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  riscv_muldiv_issue dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .fetch_valid_i(fetch_valid_i), .fetch_instr_i(fetch_instr_i),
    .fetch_opcode_i(fetch_opcode_i), .fetch_pc_i(fetch_pc_i),
    .fetch_rd_idx_i(fetch_rd_idx_i), .fetch_ra_idx_i(fetch_ra_idx_i),
    .fetch_rb_idx_i(fetch_rb_idx_i), .fetch_accept_o(fetch_accept_o),
    .rf_ra_idx_o(rf_ra_idx_o), .rf_rb_idx_o(rf_rb_idx_o),
    .rf_ra_value_i(rf_ra_value_i), .rf_rb_value_i(rf_rb_value_i),
    .opcode_valid_o(opcode_valid_o), .opcode_instr_o(opcode_instr_o),
    .opcode_opcode_o(opcode_opcode_o), .opcode_pc_o(opcode_pc_o),
    .opcode_rd_idx_o(opcode_rd_idx_o), .opcode_ra_idx_o(opcode_ra_idx_o),
    .opcode_rb_idx_o(opcode_rb_idx_o), .opcode_ra_operand_o(opcode_ra_operand_o),
    .opcode_rb_operand_o(opcode_rb_operand_o), .stall_i(stall_i),
    .writeback_idx_i(writeback_idx_i), .writeback_value_i(writeback_value_i),
    .writeback_squash_i(writeback_squash_i),
    .rf_wr_idx_o(rf_wr_idx_o), .rf_wr_value_o(rf_wr_value_o),
    .flush_i(flush_i), .busy_o(busy_o)
  );

  // Architectural register file owned by the bench, read combinationally by the DUT.
  logic [31:0] regs [32];
  assign rf_ra_value_i = regs[rf_ra_idx_o];
  assign rf_rb_value_i = regs[rf_rb_idx_o];

  // Reference model: the op waiting to issue, and the set of registers awaiting a result.
  bit          m_valid;
  logic [55:0] m_instr;
  logic [31:0] m_opcode, m_pc;
  logic [4:0]  m_rd, m_ra, m_rb;
  bit          m_pend [32];
  int unsigned in_flight [$];
  bit          chk_en;
  int          n_chk, n_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit wb_counts();
    return !writeback_squash_i && writeback_idx_i != 5'd0;
  endfunction

  function automatic bit still_pending(input logic [4:0] r);
    if (wb_counts() && r == writeback_idx_i) return 1'b0;
    return m_pend[r];
  endfunction

  function automatic logic [31:0] exp_operand(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_counts() && r == writeback_idx_i) return writeback_value_i;
    return regs[r];
  endfunction

  task automatic idle();
    rst_i = 1'b0; fetch_valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    writeback_idx_i = 5'd0; writeback_value_i = 32'd0; writeback_squash_i = 1'b0;
  endtask

  task automatic fetch(input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb);
    logic [55:0] one = 56'd1;
    fetch_valid_i  = 1'b1;
    fetch_instr_i  = one << $urandom_range(55, 0);
    fetch_opcode_i = $urandom;
    fetch_pc_i     = {$urandom_range(32'h3fff_ffff, 0), 2'b00};
    fetch_rd_idx_i = rd; fetch_ra_idx_i = ra; fetch_rb_idx_i = rb;
  endtask

  task automatic writeback(input logic [4:0] idx, input logic [31:0] val, input bit squash);
    writeback_idx_i = idx; writeback_value_i = val; writeback_squash_i = squash;
  endtask

  // Compare all outputs against the model for the current inputs, then advance one clock.
  task automatic cycle();
    bit exp_valid, fire, accept, any_pend;
    #1;
    exp_valid = m_valid && !(still_pending(m_ra) || still_pending(m_rb) || still_pending(m_rd));
    fire      = exp_valid && !stall_i;
    accept    = !flush_i && (!m_valid || fire);
    any_pend  = 1'b0;
    for (int i = 0; i < 32; i++) any_pend |= m_pend[i];
    if (chk_en) begin
      check_eq("accept", fetch_accept_o, accept);
      check_eq("valid", opcode_valid_o, exp_valid);
      check_eq("busy", busy_o, m_valid || any_pend);
      check_eq("rf_wr_idx", rf_wr_idx_o, writeback_squash_i ? 5'd0 : writeback_idx_i);
      check_eq("rf_wr_value", rf_wr_value_o, writeback_value_i);
      check_eq("instr", opcode_instr_o, m_instr);
      check_eq("opcode", opcode_opcode_o, m_opcode);
      check_eq("pc", opcode_pc_o, m_pc);
      check_eq("idx", {opcode_rd_idx_o, opcode_ra_idx_o, opcode_rb_idx_o}, {m_rd, m_ra, m_rb});
      check_eq("ra_operand", opcode_ra_operand_o, exp_operand(m_ra));
      check_eq("rb_operand", opcode_rb_operand_o, exp_operand(m_rb));
    end
    @(posedge clk_i);
    if (!writeback_squash_i && writeback_idx_i != 5'd0) regs[writeback_idx_i] = writeback_value_i;
    if (rst_i) begin
      m_valid = 1'b0; m_instr = '0; m_opcode = '0; m_pc = '0;
      m_rd = '0; m_ra = '0; m_rb = '0;
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      in_flight.delete();
      chk_en = 1'b1;
    end else begin
      if (writeback_idx_i != 5'd0) m_pend[writeback_idx_i] = 1'b0;
      if (fire && m_rd != 5'd0) begin
        m_pend[m_rd] = 1'b1;
        in_flight.push_back(m_rd);
      end
      if (fetch_valid_i && accept) begin
        m_valid = 1'b1; m_instr = fetch_instr_i; m_opcode = fetch_opcode_i; m_pc = fetch_pc_i;
        m_rd = fetch_rd_idx_i; m_ra = fetch_ra_idx_i; m_rb = fetch_rb_idx_i;
      end else if (fire || flush_i) begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    idle(); rst_i = 1'b1;
    cycle(); cycle();
    idle();
  endtask

  initial begin
    n_chk = 0; n_fail = 0; chk_en = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'd0; regs[1] = 32'd6; regs[2] = 32'd7; regs[5] = 32'd9;
    fetch_instr_i = '0; fetch_opcode_i = '0; fetch_pc_i = '0;
    fetch_rd_idx_i = '0; fetch_ra_idx_i = '0; fetch_rb_idx_i = '0;
    @(negedge clk_i);
    do_reset();

    // Post-reset outputs
    #1;
    check_eq("rst_valid", opcode_valid_o, 1'b0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_accept", fetch_accept_o, 1'b1);
    check_eq("rst_pc", opcode_pc_o, 32'd0);

    // MUL x3,x1,x2 then writeback 42
    fetch(5'd3, 5'd1, 5'd2); cycle(); idle();
    #1; check_eq("mul_valid", opcode_valid_o, 1'b1);
    check_eq("mul_ra", opcode_ra_operand_o, 32'd6);
    check_eq("mul_rb", opcode_rb_operand_o, 32'd7);
    cycle();
    #1; check_eq("mul_busy", busy_o, 1'b1);
    cycle();
    writeback(5'd3, 32'd42, 1'b0);
    #1; check_eq("wb_idx", rf_wr_idx_o, 5'd3);
    check_eq("wb_val", rf_wr_value_o, 32'd42);
    cycle(); idle();
    #1; check_eq("idle_busy", busy_o, 1'b0);
    cycle();

    // MUL x3 then dependent DIVU x4,x3,x5 issues on the writeback cycle
    fetch(5'd3, 5'd1, 5'd2); cycle();
    fetch(5'd4, 5'd3, 5'd5); cycle(); idle();
    #1; check_eq("raw_held", opcode_valid_o, 1'b0);
    cycle(); cycle();
    writeback(5'd3, 32'd42, 1'b0);
    #1; check_eq("fwd_valid", opcode_valid_o, 1'b1);
    check_eq("fwd_ra", opcode_ra_operand_o, 32'd42);
    check_eq("fwd_rb", opcode_rb_operand_o, 32'd9);
    cycle(); idle();
    writeback(5'd4, 32'd6, 1'b0); cycle(); idle();

    // Stall for three cycles, issue on the fourth
    fetch(5'd6, 5'd1, 5'd2); cycle();
    fetch(5'd7, 5'd2, 5'd1); stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; check_eq("stall_accept", fetch_accept_o, 1'b0);
      cycle();
    end
    stall_i = 1'b0;
    #1; check_eq("stall_release", fetch_accept_o, 1'b1);
    cycle(); idle(); cycle();
    writeback(5'd6, 32'd1, 1'b0); cycle();
    writeback(5'd7, 32'd2, 1'b0); cycle(); idle();

    // x0 destination sets nothing; reader of x0 gets 0
    fetch(5'd0, 5'd1, 5'd2); cycle();
    fetch(5'd8, 5'd0, 5'd0); cycle(); idle();
    #1; check_eq("x0_valid", opcode_valid_o, 1'b1);
    check_eq("x0_operand", opcode_ra_operand_o, 32'd0);
    cycle();
    writeback(5'd8, 32'd3, 1'b0); cycle(); idle();

    // Flush while stalled, then squashed writeback
    fetch(5'd9, 5'd1, 5'd2); cycle();
    fetch(5'd10, 5'd1, 5'd2); cycle(); idle();
    stall_i = 1'b1; flush_i = 1'b1; cycle(); idle();
    writeback(5'd9, 32'hdead, 1'b1);
    #1; check_eq("flush_valid", opcode_valid_o, 1'b0);
    check_eq("squash_idx", rf_wr_idx_o, 5'd0);
    cycle(); idle();
    #1; check_eq("squash_busy", busy_o, 1'b0);
    cycle();

    // Reset with x7 pending; a late writeback still reaches the register file
    fetch(5'd7, 5'd1, 5'd2); cycle(); idle(); cycle();
    #1; check_eq("pre_rst_busy", busy_o, 1'b1);
    rst_i = 1'b1; cycle(); idle();
    #1; check_eq("post_rst_busy", busy_o, 1'b0);
    writeback(5'd7, 32'h77, 1'b0);
    #1; check_eq("late_wb", rf_wr_idx_o, 5'd7);
    cycle(); idle();

    // Random traffic with a mul/div unit that retires ops in order after random delays
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      idle();
      if ($urandom_range(2, 0) != 0)
        fetch(5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)));
      stall_i = ($urandom_range(3, 0) == 0);
      flush_i = ($urandom_range(15, 0) == 0);
      if (in_flight.size() != 0 && $urandom_range(2, 0) == 0)
        writeback(5'(in_flight.pop_front()), $urandom, $urandom_range(5, 0) == 0);
      cycle();
    end
    idle();
    for (int n = 0; n < 20 && in_flight.size() != 0; n++) begin
      writeback(5'(in_flight.pop_front()), $urandom, 1'b0);
      cycle(); idle();
    end
    cycle(); cycle();
    #1; check_eq("drain_busy", busy_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_muldiv_issue.md
RISCV_MULDIV_ISSUE -- requirements
Module: riscv_muldiv_issue

Interface
REQ-001 SHALL have ports: clk_i  in  1  clock; rst_i  in  1  reset; one clock, reset synchronous and active-high.
REQ-002 SHALL have ports: fetch_valid_i  in  1  decode op valid; fetch_instr_i  in  56  one-hot ENUM_INST vector; fetch_opcode_i, fetch_pc_i  in  32 each; fetch_rd_idx_i, fetch_ra_idx_i, fetch_rb_idx_i  in  5 each; fetch_accept_o  out  1  op taken.
REQ-003 SHALL have ports: rf_ra_idx_o, rf_rb_idx_o  out  5  register file read addresses; rf_ra_value_i, rf_rb_value_i  in  32  combinational read data.
REQ-004 SHALL have ports: opcode_valid_o  out  1; opcode_instr_o  out  56; opcode_opcode_o, opcode_pc_o  out  32; opcode_rd_idx_o, opcode_ra_idx_o, opcode_rb_idx_o  out  5; opcode_ra_operand_o, opcode_rb_operand_o  out  32; stall_i  in  1  mul/div unit busy.
REQ-005 SHALL have ports: writeback_idx_i  in  5; writeback_value_i  in  32; writeback_squash_i  in  1; all three from the mul/div unit.
REQ-006 SHALL have ports: rf_wr_idx_o  out  5  (0 = no write); rf_wr_value_o  out  32; flush_i  in  1  discard unissued op; busy_o  out  1.

Function
REQ-007 SHALL hold a one-entry issue register (valid, instr, opcode, pc, rd, ra, rb) loaded on fetch_valid_i && fetch_accept_o.
REQ-008 SHALL drive fetch_accept_o = !flush_i && (!issue_valid_q || issue_fire_w).
REQ-009 SHALL define issue_fire_w = opcode_valid_o && !stall_i, with opcode_valid_o = issue_valid_q && !hazard_w.
REQ-010 SHALL keep a 32-bit pending scoreboard; bit 0 SHALL be constant 0.
REQ-011 SHALL define hazard_w as the effective pending bit set for the issue-register ra, rb or rd (RAW and WAW); effective pending = pending_q with the bit for this cycle's non-squashed writeback_idx_i cleared.
REQ-012 SHALL set pending[rd] on issue_fire_w when rd != 0.
REQ-013 SHALL clear pending[writeback_idx_i] when writeback_idx_i != 0, regardless of writeback_squash_i.
REQ-014 SHALL let set win over clear when both target the same index in one cycle.
REQ-015 SHALL drive rf_ra_idx_o/rf_rb_idx_o from the issue register.
REQ-016 SHALL form each operand as: 0 if its index is 0; else writeback_value_i if the index equals writeback_idx_i and squash = 0; else rf_*_value_i.
REQ-017 SHALL drive opcode_* fields straight from the issue register, even when opcode_valid_o = 0.
REQ-018 SHALL hold opcode_* stable while opcode_valid_o && stall_i.
REQ-019 SHALL pass writeback combinationally to the register file: rf_wr_idx_o = squash ? 0 : writeback_idx_i, and rf_wr_value_o = writeback_value_i.
REQ-020 SHALL make issue-to-operand forwarding zero-bubble: an op dependent on a writeback issues in the same cycle as that writeback.
REQ-021 SHALL, on flush_i, clear issue_valid_q next cycle, including while stall_i is high; flush SHALL NOT take effect in a cycle where issue_fire_w = 1; pending SHALL be untouched.
REQ-022 SHALL drive busy_o = issue_valid_q || |pending_q.
REQ-023 SHALL, on simultaneous issue_fire_w and fetch accept, replace the issue register contents with no bubble.

Reset
REQ-024 SHALL, while rst_i = 1 at a clock edge, clear issue_valid_q, the issue-register fields and pending_q to 0.
REQ-025 SHALL give these output values after reset: opcode_valid_o = 0, opcode fields = 0, busy_o = 0, fetch_accept_o = 1.
REQ-026 SHALL, on reset mid-operation, discard all pending state; late writebacks SHALL still pass to the register file per REQ-019.

Verification
REQ-027 SHALL cover: MUL x3,x1,x2 with x1=6, x2=7 -> opcode_valid_o one cycle, pending[3] set; writeback_idx_i=3, value 42 -> rf_wr_idx_o=3, rf_wr_value_o=42, pending[3] cleared, busy_o=0 next cycle.
REQ-028 SHALL cover: MUL x3 then DIVU x4,x3,x5 -> DIVU held (opcode_valid_o=0) until the writeback of x3; it issues that same cycle with opcode_ra_operand_o = 42 (forwarded).
REQ-029 SHALL cover: stall_i high 3 cycles with op valid -> opcode fields unchanged, fetch_accept_o=0, pending unchanged; issue on the 4th cycle.
REQ-030 SHALL cover: MUL x0,x1,x2 -> no pending bit set; a following op reading x0 issues immediately with operand 0.
REQ-031 SHALL cover: flush_i while stalled -> issue_valid_q=0 next cycle, no issue; a squashed writeback clears pending with rf_wr_idx_o=0.
REQ-032 SHALL cover: rst_i asserted with pending[7] set -> pending_q=0 and busy_o=0 after the edge.
